// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array sequencing controller:
// FSM state encoding, array geometry and drain length.
package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } sa_state_e;

  localparam int ARR_DIM   = 4;
  localparam int DRAIN_LEN = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// Handshake, operand-buffer and array-feed signals of sa_seq_ctrl.
// perf_cycles only exists when SA_CTRL_PERF_EN is defined.
interface sa_seq_ctrl_if
  import sa_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic                      start;
  logic [4:0]                k_len;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic                      op_rd_en;
  logic [3:0]                op_rd_k;
  logic [ARR_DIM*DATA_W-1:0] a_col_in;
  logic [ARR_DIM*DATA_W-1:0] b_row_in;
  logic [ARR_DIM*DATA_W-1:0] arr_a;
  logic [ARR_DIM*DATA_W-1:0] arr_b;
  logic                      arr_clr;
`ifdef SA_CTRL_PERF_EN
  logic [15:0]               perf_cycles;
`endif

  modport master (
    output start, k_len, a_col_in, b_row_in,
    input  busy, done, err, op_rd_en, op_rd_k, arr_a, arr_b, arr_clr
`ifdef SA_CTRL_PERF_EN
    , input perf_cycles
`endif
  );

  modport slave (
    input  start, k_len, a_col_in, b_row_in,
    output busy, done, err, op_rd_en, op_rd_k, arr_a, arr_b, arr_clr
`ifdef SA_CTRL_PERF_EN
    , output perf_cycles
`endif
  );

endinterface

// File: rtl/sa_skew_line.sv
// Fixed-depth delay line for one array lane; shifts in zero whenever
// the incoming sample is not a valid operand read.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = vld ? din : '0;
    for (int s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_seq_ctrl.sv
// Job sequencer for a 4x4 output-stationary systolic array: clears the array,
// streams K operand columns/rows with per-lane skew, drains, then signals done.
// Optional busy-cycle counter perf_cycles is enabled by defining SA_CTRL_PERF_EN.
module sa_seq_ctrl
  import sa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int K_MAX  = 16
) (
  input  logic         clk,
  input  logic         reset,
  sa_seq_ctrl_if.slave bus
);

  localparam logic [5:0] K_MAX_W = 6'(K_MAX);

  sa_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] k_q, k_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       arr_clr_q, arr_clr_d;
  logic       rd_en_q, rd_en_d;
  logic [3:0] rd_k_q, rd_k_d;
  logic       rd_vld_q, rd_vld_d;
  logic       k_ok;
`ifdef SA_CTRL_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic [15:0] perf_cycles_q, perf_cycles_d;
`endif

  assign k_ok = (bus.k_len != 5'd0) && ({1'b0, bus.k_len} <= K_MAX_W);

  // Outputs are computed for the next state so they come straight from flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    arr_clr_d = 1'b0;
    rd_en_d   = 1'b0;
    rd_k_d    = 4'd0;
    rd_vld_d  = rd_en_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (k_ok) begin
            state_d   = ST_CLEAR;
            k_d       = bus.k_len;
            busy_d    = 1'b1;
            arr_clr_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        cnt_d   = 4'd0;
        rd_en_d = 1'b1;
        rd_k_d  = 4'd0;
      end
      ST_FEED: begin
        if ({1'b0, cnt_q} == k_q - 5'd1) begin
          state_d = ST_DRAIN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          rd_en_d = 1'b1;
          rd_k_d  = cnt_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 4'(DRAIN_LEN - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
`ifdef SA_CTRL_PERF_EN
    perf_cnt_d    = (state_q == ST_IDLE) ? 16'd0 : sat_inc16(perf_cnt_q);
    perf_cycles_d = (state_q == ST_DONE) ? perf_cnt_d : perf_cycles_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      k_q       <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      arr_clr_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_k_q    <= 4'd0;
      rd_vld_q  <= 1'b0;
`ifdef SA_CTRL_PERF_EN
      perf_cnt_q    <= 16'd0;
      perf_cycles_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      arr_clr_q <= arr_clr_d;
      rd_en_q   <= rd_en_d;
      rd_k_q    <= rd_k_d;
      rd_vld_q  <= rd_vld_d;
`ifdef SA_CTRL_PERF_EN
      perf_cnt_q    <= perf_cnt_d;
      perf_cycles_q <= perf_cycles_d;
`endif
    end
  end

  // Lane i sees its operand i+1 cycles after the buffer returns it.
  logic [ARR_DIM*DATA_W-1:0] arr_a_w;
  logic [ARR_DIM*DATA_W-1:0] arr_b_w;

  for (genvar i = 0; i < ARR_DIM; i++) begin : g_lane
    sa_skew_line #(.DATA_W(DATA_W), .DEPTH(i + 1)) u_skew_a (
      .clk   (clk),
      .reset (reset),
      .vld   (rd_vld_q),
      .din   (bus.a_col_in[i*DATA_W +: DATA_W]),
      .dout  (arr_a_w[i*DATA_W +: DATA_W])
    );
    sa_skew_line #(.DATA_W(DATA_W), .DEPTH(i + 1)) u_skew_b (
      .clk   (clk),
      .reset (reset),
      .vld   (rd_vld_q),
      .din   (bus.b_row_in[i*DATA_W +: DATA_W]),
      .dout  (arr_b_w[i*DATA_W +: DATA_W])
    );
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.op_rd_en = rd_en_q;
  assign bus.op_rd_k  = rd_k_q;
  assign bus.arr_a    = arr_a_w;
  assign bus.arr_b    = arr_b_w;
  // The array reset follows our reset so it is cleared on every edge while held.
  assign bus.arr_clr  = arr_clr_q | ~reset;
`ifdef SA_CTRL_PERF_EN
  assign bus.perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Self-checking bench for sa_seq_ctrl: operand buffer and 4x4 systolic array
// models around the DUT, table-driven jobs plus reset and back-to-back sequences.
module tb_sa_seq_ctrl;
  import sa_pkg::*;

  localparam int DW   = 32;
  localparam int NVEC = 7;

  typedef struct {
    logic [4:0] k_len;
    int         pat;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sa_seq_ctrl_if #(.DATA_W(DW)) bus ();

  sa_seq_ctrl #(.DATA_W(DW), .K_MAX(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   pat = 0;
  vec_t vecs [NVEC];
  int   exp_c [NVEC][16];
  int   exp_136 [16];

  // Operand patterns: A[i][k] and B[k][j] served by the buffer model.
  function automatic logic [31:0] a_val(input int p, input int i, input int k);
    case (p)
      0:       return (i == k) ? 32'd1 : 32'd0;
      1, 2:    return 32'(i + 1);
      default: return 32'(k + 1);
    endcase
  endfunction

  function automatic logic [31:0] b_val(input int p, input int k, input int j);
    case (p)
      0:       return 32'(k * 4 + j + 1);
      1:       return 32'(j + 5);
      2:       return 32'(j + 1);
      default: return 32'd1;
    endcase
  endfunction

  // Buffer answers a read one cycle later; non-read cycles carry junk.
  logic       rd_pend = 1'b0;
  logic [3:0] rd_k = 4'd0;
  always @(negedge clk) begin
    rd_pend = bus.op_rd_en;
    rd_k    = bus.op_rd_k;
  end

  always @(posedge clk) begin
    logic [4*DW-1:0] a_v, b_v;
    #1;
    for (int l = 0; l < 4; l++) begin
      a_v[l*DW +: DW] = rd_pend ? a_val(pat, l, int'(rd_k)) : (32'hA5A50000 | 32'(l));
      b_v[l*DW +: DW] = rd_pend ? b_val(pat, int'(rd_k), l) : (32'h5A5A0000 | 32'(l));
    end
    bus.a_col_in = a_v;
    bus.b_row_in = b_v;
  end

  // Output-stationary 4x4 array with synchronous active-high clear.
  logic [31:0] acc [4][4];
  logic [31:0] ar  [4][4];
  logic [31:0] br  [4][4];
  always @(posedge clk) begin
    logic [31:0] ai, bi;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (bus.arr_clr) begin
          acc[i][j] <= 32'd0;
          ar[i][j]  <= 32'd0;
          br[i][j]  <= 32'd0;
        end else begin
          if (j == 0) ai = bus.arr_a[i*DW +: DW];
          else        ai = ar[i][j-1];
          if (i == 0) bi = bus.arr_b[j*DW +: DW];
          else        bi = br[i-1][j];
          acc[i][j] <= acc[i][j] + ai * bi;
          ar[i][j]  <= ai;
          br[i][j]  <= bi;
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] k, input int p);
    pat       = p;
    bus.k_len = k;
    bus.start = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic checkMatrix(input string name, input int expm [16]);
    int bad;
    bad = -1;
    checks++;
    for (int idx = 0; idx < 16; idx++) begin
      if (bad < 0 && acc[idx/4][idx%4] !== 32'(expm[idx])) bad = idx;
    end
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s c[%0d][%0d] got=%0d expected=%0d", name, bad / 4, bad % 4,
               acc[bad/4][bad%4], expm[bad]);
    end
  endtask

  task automatic runVector(input int v);
    int   cyc;
    int   rd_cnt;
    bit   got;
    logic seen;
    logic [4*DW-1:0] ea, eb;
    applyStimulus(vecs[v].k_len, vecs[v].pat);
    stepCycle();
    cyc = 1;
    bus.start = 1'b0;
    if (vecs[v].exp_err) begin
      checkOutput("err_pulse", 128'(bus.err), 128'(1));
      checkOutput("err_busy", 128'(bus.busy), 128'(0));
      seen = 1'b0;
      repeat (4) begin
        stepCycle();
        seen = seen | bus.err | bus.busy | bus.op_rd_en;
      end
      checkOutput("err_quiet", 128'(seen), 128'(0));
    end else begin
      checkOutput("clear_arr_clr", 128'(bus.arr_clr), 128'(1));
      checkOutput("clear_busy", 128'(bus.busy), 128'(1));
      checkOutput("clear_no_read", 128'(bus.op_rd_en), 128'(0));
      rd_cnt = 0;
      got = 1'b0;
      while (!got && cyc < 80) begin
        stepCycle();
        cyc++;
        if (bus.op_rd_en) begin
          rd_cnt++;
          checkOutput("rd_k", 128'(bus.op_rd_k), 128'(cyc - 2));
        end
        if (cyc == 2) checkOutput("feed_arr_clr", 128'(bus.arr_clr), 128'(0));
        if (vecs[v].pat == 1) begin
          for (int l = 0; l < 4; l++) begin
            ea[l*DW +: DW] = (cyc == 4 + l) ? 32'(l + 1) : 32'd0;
            eb[l*DW +: DW] = (cyc == 4 + l) ? 32'(l + 5) : 32'd0;
          end
          checkOutput("skew_a", bus.arr_a, ea);
          checkOutput("skew_b", bus.arr_b, eb);
        end
        if (bus.done) got = 1'b1;
      end
      checkOutput("done_seen", 128'(got), 128'(1));
      checkOutput("latency", 128'(cyc), 128'(vecs[v].exp_lat));
      checkOutput("read_count", 128'(rd_cnt), 128'(vecs[v].k_len));
      checkMatrix("result", exp_c[v]);
      stepCycle();
      checkOutput("post_busy", 128'(bus.busy), 128'(0));
      checkOutput("post_done", 128'(bus.done), 128'(0));
      checkOutput("post_lanes", bus.arr_a | bus.arr_b, 128'(0));
`ifdef SA_CTRL_PERF_EN
      if (vecs[v].k_len == 5'd16) checkOutput("perf_cycles", 128'(bus.perf_cycles), 128'(26));
`endif
    end
  endtask

  initial begin
    int   cyc;
    int   d1;
    int   d2;
    logic err_seen;
    logic busy_a;
    logic busy_b;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.k_len = 5'd0;

    vecs[0] = '{5'd4,  0, 1'b0, 14};
    vecs[1] = '{5'd1,  1, 1'b0, 11};
    vecs[2] = '{5'd16, 2, 1'b0, 26};
    vecs[3] = '{5'd0,  0, 1'b1, 0};
    vecs[4] = '{5'd17, 0, 1'b1, 0};
    vecs[5] = '{5'd31, 0, 1'b1, 0};
    vecs[6] = '{5'd2,  3, 1'b0, 12};
    exp_c[0] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    exp_c[1] = '{5, 6, 7, 8, 10, 12, 14, 16, 15, 18, 21, 24, 20, 24, 28, 32};
    exp_c[2] = '{16, 32, 48, 64, 32, 64, 96, 128, 48, 96, 144, 192, 64, 128, 192, 256};
    exp_c[3] = '{default: 0};
    exp_c[4] = '{default: 0};
    exp_c[5] = '{default: 0};
    exp_c[6] = '{default: 3};
    exp_136  = '{default: 136};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 128'(bus.busy), 128'(0));
    checkOutput("rst_arr_clr", 128'(bus.arr_clr), 128'(1));
    checkOutput("rst_lanes", bus.arr_a | bus.arr_b, 128'(0));
    checkOutput("rst_rd_en", 128'(bus.op_rd_en), 128'(0));
    reset = 1'b1;
    stepCycle();
    checkOutput("idle_arr_clr", 128'(bus.arr_clr), 128'(0));
    checkOutput("idle_busy", 128'(bus.busy), 128'(0));

    for (int v = 0; v < NVEC; v++) begin
      runVector(v);
    end

    // Reset during FEED cycle 2 of a long job, then a clean short job.
    applyStimulus(5'd16, 2);
    stepCycle();
    bus.start = 1'b0;
    repeat (3) stepCycle();
    checkOutput("feed2_rd_k", 128'(bus.op_rd_k), 128'(2));
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 128'(bus.busy), 128'(0));
    checkOutput("mid_rst_rd_en", 128'(bus.op_rd_en), 128'(0));
    checkOutput("mid_rst_rd_k", 128'(bus.op_rd_k), 128'(0));
    checkOutput("mid_rst_done_err", 128'({bus.done, bus.err}), 128'(0));
    checkOutput("mid_rst_arr_a", bus.arr_a, 128'(0));
    checkOutput("mid_rst_arr_b", bus.arr_b, 128'(0));
    checkOutput("mid_rst_arr_clr", 128'(bus.arr_clr), 128'(1));
    repeat (2) stepCycle();
    checkOutput("rst_hold_clr", 128'(bus.arr_clr), 128'(1));
    reset = 1'b1;
    stepCycle();
    runVector(0);

    // Start held high across two K=16 jobs.
    pat       = 2;
    bus.k_len = 5'd16;
    bus.start = 1'b1;
    cyc = 0;
    d1 = 0;
    d2 = 0;
    err_seen = 1'b0;
    busy_a = 1'b1;
    busy_b = 1'b0;
    while (d2 == 0 && cyc < 120) begin
      stepCycle();
      cyc++;
      if (bus.err) err_seen = 1'b1;
      if (d1 != 0 && cyc == d1 + 1) busy_a = bus.busy;
      if (d1 != 0 && cyc == d1 + 2) busy_b = bus.busy;
      if (bus.done) begin
        if (d1 == 0) begin
          d1  = cyc;
          pat = 3;
          checkMatrix("b2b_first", exp_c[2]);
        end else begin
          d2 = cyc;
        end
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b_done1", 128'(d1), 128'(26));
    checkOutput("b2b_done2", 128'(d2), 128'(53));
    checkOutput("b2b_idle_gap", 128'(busy_a), 128'(0));
    checkOutput("b2b_restart", 128'(busy_b), 128'(1));
    checkOutput("b2b_no_err", 128'(err_seen), 128'(0));
    checkMatrix("b2b_second", exp_136);
    stepCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
